// File: rtl/prt_scaler_pkg.sv
// Shared scaler definitions: VPS stream geometry and the parameter index map
// used by both the control block and the VPS receiver.
package prt_scaler_pkg;

    localparam int P_VPS_IDX_WIDTH = 4;
    localparam int P_VPS_DAT_WIDTH = 16;
    localparam int P_VPS_NUM       = 16;

    typedef enum logic [P_VPS_IDX_WIDTH-1:0] {
        VPS_SRC_WIDTH  = 4'd0,
        VPS_SRC_HEIGHT = 4'd1,
        VPS_DST_WIDTH  = 4'd2,
        VPS_DST_HEIGHT = 4'd3,
        VPS_H_RATIO    = 4'd4,
        VPS_V_RATIO    = 4'd5,
        VPS_H_PHASE    = 4'd6,
        VPS_V_PHASE    = 4'd7,
        VPS_CROP_X     = 4'd8,
        VPS_CROP_Y     = 4'd9,
        VPS_CROP_W     = 4'd10,
        VPS_CROP_H     = 4'd11,
        VPS_FILL_Y     = 4'd12,
        VPS_FILL_C     = 4'd13,
        VPS_CTRL       = 4'd14,
        VPS_RSVD       = 4'd15
    } vps_idx_e;

endpackage

// File: rtl/prt_scaler_vps_rx_if.sv
// Bundle of the VPS receive stream, frame-start strobe and active parameter outputs.
// The master drives the stream; the slave is the receiver.
interface prt_scaler_vps_rx_if
    import prt_scaler_pkg::*;
#(
    parameter int P_IDX_WIDTH = P_VPS_IDX_WIDTH,
    parameter int P_DAT_WIDTH = P_VPS_DAT_WIDTH,
    parameter int P_VPS_NUM   = prt_scaler_pkg::P_VPS_NUM
);
    logic                             CTL_RUN_IN;
    logic [P_IDX_WIDTH-1:0]           VPS_IDX_IN;
    logic [P_DAT_WIDTH-1:0]           VPS_DAT_IN;
    logic                             VPS_VLD_IN;
    logic                             VID_FS_IN;
    logic [P_VPS_NUM*P_DAT_WIDTH-1:0] PAR_OUT;
    logic                             PAR_VLD_OUT;
    logic                             PAR_UPD_OUT;
    logic                             ERR_OUT;

    modport master (
        output CTL_RUN_IN, VPS_IDX_IN, VPS_DAT_IN, VPS_VLD_IN, VID_FS_IN,
        input  PAR_OUT, PAR_VLD_OUT, PAR_UPD_OUT, ERR_OUT
    );

    modport slave (
        input  CTL_RUN_IN, VPS_IDX_IN, VPS_DAT_IN, VPS_VLD_IN, VID_FS_IN,
        output PAR_OUT, PAR_VLD_OUT, PAR_UPD_OUT, ERR_OUT
    );

endinterface

// File: rtl/prt_scaler_vps_rx.sv
// VPS receiver: captures one complete in-order sweep into a pending bank and
// commits it to the active parameters on the next frame start (tear-free update).
module prt_scaler_vps_rx
    import prt_scaler_pkg::*;
#(
    parameter int P_IDX_WIDTH = P_VPS_IDX_WIDTH,
    parameter int P_DAT_WIDTH = P_VPS_DAT_WIDTH,
    parameter int P_VPS_NUM   = prt_scaler_pkg::P_VPS_NUM  // must equal 2**P_IDX_WIDTH
) (
    input logic                VID_CLK_IN,
    input logic                VID_RST_IN,
    prt_scaler_vps_rx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPT
    } state_e;

    localparam logic [P_IDX_WIDTH-1:0] LAST_IDX = P_IDX_WIDTH'(P_VPS_NUM - 1);

    state_e                           state;
    logic [P_IDX_WIDTH-1:0]           exp_idx;
    logic [P_DAT_WIDTH-1:0]           cap [P_VPS_NUM];
    logic [P_VPS_NUM*P_DAT_WIDTH-1:0] pend;
    logic [P_VPS_NUM*P_DAT_WIDTH-1:0] act;
    logic                             pend_vld;
    logic                             par_vld;
    logic                             par_upd;
    logic                             err;

    assign bus.PAR_OUT     = act;
    assign bus.PAR_VLD_OUT = par_vld;
    assign bus.PAR_UPD_OUT = par_upd;
    assign bus.ERR_OUT     = err;

    always_ff @(posedge VID_CLK_IN) begin
        if (VID_RST_IN) begin
            state    <= IDLE;
            exp_idx  <= '0;
            pend     <= '0;
            act      <= '0;
            pend_vld <= 1'b0;
            par_vld  <= 1'b0;
            par_upd  <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < P_VPS_NUM; i++) begin
                cap[i] <= '0;
            end
        end else begin
            par_upd <= 1'b0;

            // Commit looks at the registered pend_vld, so a sweep finishing in this
            // same cycle is not committed yet; the old pend goes out instead.
            if (bus.VID_FS_IN && pend_vld) begin
                act      <= pend;
                par_vld  <= 1'b1;
                par_upd  <= 1'b1;
                pend_vld <= 1'b0;
            end

            if (!bus.CTL_RUN_IN) begin
                state    <= IDLE;
                exp_idx  <= '0;
                pend_vld <= 1'b0;
                err      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SYNC;
                    end
                    SYNC: begin
                        if (bus.VPS_VLD_IN && bus.VPS_IDX_IN == '0) begin
                            cap[0]  <= bus.VPS_DAT_IN;
                            exp_idx <= P_IDX_WIDTH'(1);
                            state   <= CAPT;
                        end
                    end
                    CAPT: begin
                        if (bus.VPS_VLD_IN) begin
                            if (bus.VPS_IDX_IN == exp_idx) begin
                                cap[exp_idx] <= bus.VPS_DAT_IN;
                                exp_idx      <= exp_idx + 1'b1;
                                // Last index bypasses cap so the set lands in pend in one step.
                                if (exp_idx == LAST_IDX) begin
                                    for (int i = 0; i < P_VPS_NUM - 1; i++) begin
                                        pend[i*P_DAT_WIDTH +: P_DAT_WIDTH] <= cap[i];
                                    end
                                    pend[(P_VPS_NUM-1)*P_DAT_WIDTH +: P_DAT_WIDTH] <= bus.VPS_DAT_IN;
                                    pend_vld <= 1'b1;
                                end
                            end else begin
                                err <= 1'b1;
                                if (bus.VPS_IDX_IN == '0) begin
                                    cap[0]  <= bus.VPS_DAT_IN;
                                    exp_idx <= P_IDX_WIDTH'(1);
                                    state   <= CAPT;
                                end else begin
                                    exp_idx <= '0;
                                    state   <= SYNC;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
